// File: rtl/rbsp_bit_window.sv
// RBSP bit feeder: strips 00 00 03 emulation-prevention bytes from NAL payload and
// exposes the next 8 RBSP bits (MSB first) with their leading-zero count.
module rbsp_bit_window #(
  parameter int BUF_BITS = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            i_flush,
  input  logic [7:0]                      i_byte_data,
  input  logic                            i_byte_valid,
  output logic                            o_byte_ready,
  input  logic [3:0]                      i_forward_len,
  output logic [7:0]                      o_rbsp_out,
  output logic [3:0]                      o_num_zero_bits,
  output logic                            o_rbsp_valid,
  output logic [$clog2(BUF_BITS+1)-1:0]   o_bits_avail,
  output logic                            o_epb_removed,
  output logic                            o_underflow
);

  localparam int CW = $clog2(BUF_BITS + 1);

  logic [BUF_BITS-1:0] bitBuf_q, bitBuf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          zeroRun_q, zeroRun_d;
  logic                epbPulse_q, epbPulse_d;
  logic                underflowPulse_q, underflowPulse_d;

  logic [3:0]          fwdSat;
  logic [CW-1:0]       fwdExt;
  logic [CW-1:0]       fwdEff;
  logic [CW-1:0]       cntPost;
  logic                underflowNow;
  logic                accept;
  logic                isEpb;
  logic [BUF_BITS-1:0] byteAligned;

  // Ready is conservative: it ignores bits freed by a same-cycle consume.
  assign o_byte_ready = en & ~rst & ~i_flush & (cnt_q <= CW'(BUF_BITS - 8));
  assign o_rbsp_out   = bitBuf_q[BUF_BITS-1 -: 8];
  assign o_rbsp_valid = (cnt_q >= CW'(8));
  assign o_bits_avail = cnt_q;
  assign o_epb_removed = epbPulse_q;
  assign o_underflow   = underflowPulse_q;

  always_comb begin
    casez (o_rbsp_out)
      8'b1???????: o_num_zero_bits = 4'd0;
      8'b01??????: o_num_zero_bits = 4'd1;
      8'b001?????: o_num_zero_bits = 4'd2;
      8'b0001????: o_num_zero_bits = 4'd3;
      8'b00001???: o_num_zero_bits = 4'd4;
      8'b000001??: o_num_zero_bits = 4'd5;
      8'b0000001?: o_num_zero_bits = 4'd6;
      8'b00000001: o_num_zero_bits = 4'd7;
      default:     o_num_zero_bits = 4'd8;
    endcase
  end

  // Consume first, then append the accepted byte right below the surviving bits.
  always_comb begin
    fwdSat       = (i_forward_len > 4'd8) ? 4'd8 : i_forward_len;
    fwdExt       = CW'(fwdSat);
    underflowNow = (fwdExt > cnt_q);
    fwdEff       = underflowNow ? '0 : fwdExt;
    cntPost      = cnt_q - fwdEff;
    accept       = i_byte_valid & o_byte_ready;
    isEpb        = accept & (i_byte_data == 8'h03) & (zeroRun_q == 2'd2);
    byteAligned  = {i_byte_data, {(BUF_BITS-8){1'b0}}} >> cntPost;

    bitBuf_d         = bitBuf_q;
    cnt_d            = cnt_q;
    zeroRun_d        = zeroRun_q;
    epbPulse_d       = 1'b0;
    underflowPulse_d = 1'b0;

    if (i_flush) begin
      bitBuf_d  = '0;
      cnt_d     = '0;
      zeroRun_d = 2'd0;
    end else if (en) begin
      bitBuf_d         = bitBuf_q << fwdEff;
      cnt_d            = cntPost;
      underflowPulse_d = underflowNow;
      epbPulse_d       = isEpb;
      if (accept) begin
        if (isEpb) begin
          zeroRun_d = 2'd0;
        end else begin
          bitBuf_d = bitBuf_d | byteAligned;
          cnt_d    = cntPost + CW'(8);
          if (i_byte_data == 8'h00)
            zeroRun_d = (zeroRun_q == 2'd2) ? 2'd2 : zeroRun_q + 2'd1;
          else
            zeroRun_d = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitBuf_q         <= '0;
      cnt_q            <= '0;
      zeroRun_q        <= 2'd0;
      epbPulse_q       <= 1'b0;
      underflowPulse_q <= 1'b0;
    end else begin
      bitBuf_q         <= bitBuf_d;
      cnt_q            <= cnt_d;
      zeroRun_q        <= zeroRun_d;
      epbPulse_q       <= epbPulse_d;
      underflowPulse_q <= underflowPulse_d;
    end
  end

endmodule

// File: tb/tb_rbsp_bit_window.sv
// Directed table-driven bench for rbsp_bit_window: each row drives one clock edge and
// compares every output against hand-computed values.
module tb_rbsp_bit_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       i_flush;
  logic [7:0] i_byte_data;
  logic       i_byte_valid;
  logic       o_byte_ready;
  logic [3:0] i_forward_len;
  logic [7:0] o_rbsp_out;
  logic [3:0] o_num_zero_bits;
  logic       o_rbsp_valid;
  logic [5:0] o_bits_avail;
  logic       o_epb_removed;
  logic       o_underflow;

  int checks   = 0;
  int failures = 0;

  rbsp_bit_window #(.BUF_BITS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i_flush        (i_flush),
    .i_byte_data    (i_byte_data),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .i_forward_len  (i_forward_len),
    .o_rbsp_out     (o_rbsp_out),
    .o_num_zero_bits(o_num_zero_bits),
    .o_rbsp_valid   (o_rbsp_valid),
    .o_bits_avail   (o_bits_avail),
    .o_epb_removed  (o_epb_removed),
    .o_underflow    (o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       en;
    logic       bv;
    logic [7:0] data;
    logic [3:0] fwd;
    logic [5:0] avail;
    logic [7:0] out;
    logic [3:0] zeros;
    logic       rv;
    logic       epb;
    logic       uf;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic e, input logic bv, input logic [7:0] d,
                              input logic [3:0] f, input logic [5:0] av, input logic [7:0] o,
                              input logic [3:0] z, input logic rv, input logic ep, input logic u,
                              input logic rd);
    vec_t v;
    v.flush = fl; v.en = e; v.bv = bv; v.data = d; v.fwd = f;
    v.avail = av; v.out = o; v.zeros = z; v.rv = rv; v.epb = ep; v.uf = u; v.rdy = rd;
    return v;
  endfunction

  // Drive one set of inputs, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic fl, input logic e, input logic bv,
                               input logic [7:0] d, input logic [3:0] f);
    i_flush       = fl;
    en            = e;
    i_byte_valid  = bv;
    i_byte_data   = d;
    i_forward_len = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input int idx, input vec_t v);
    checkOutput("bits_avail", idx, 8'(o_bits_avail), 8'(v.avail));
    checkOutput("rbsp_out",   idx, o_rbsp_out, v.out);
    checkOutput("num_zeros",  idx, 8'(o_num_zero_bits), 8'(v.zeros));
    checkOutput("rbsp_valid", idx, 8'(o_rbsp_valid), 8'(v.rv));
    checkOutput("epb_removed", idx, 8'(o_epb_removed), 8'(v.epb));
    checkOutput("underflow",  idx, 8'(o_underflow), 8'(v.uf));
    checkOutput("byte_ready", idx, 8'(o_byte_ready), 8'(v.rdy));
  endtask

  initial begin
    //                fl e  bv data   fwd  avail out    z  rv ep uf rdy
    // A5 3C then consume 4
    vecs.push_back(mk(0, 1, 1, 8'hA5, 0,  8,  8'hA5, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h3C, 0, 16,  8'hA5, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 12,  8'h53, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0,  0,  8'h00, 8, 0, 0, 0, 0));
    // 00 00 03 01: the 03 is dropped
    vecs.push_back(mk(0, 1, 1, 8'h00, 0,  8,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 16,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h03, 0, 16,  8'h00, 8, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h01, 0, 24,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8, 16,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8,  8,  8'h01, 7, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0,  0,  8'h00, 8, 0, 0, 0, 0));
    // 00 00 00 03 80: zero run saturates, 03 still dropped
    vecs.push_back(mk(0, 1, 1, 8'h00, 0,  8,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 16,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 24,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h03, 0, 24,  8'h00, 8, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h80, 0, 32,  8'h00, 8, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8, 24,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8, 16,  8'h00, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8,  8,  8'h80, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0,  0,  8'h00, 8, 0, 0, 0, 0));
    // Fill to 32, byte 55 held through backpressure: no loss, no duplicate
    vecs.push_back(mk(0, 1, 1, 8'h11, 0,  8,  8'h11, 3, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h22, 0, 16,  8'h11, 3, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h33, 0, 24,  8'h11, 3, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h44, 0, 32,  8'h11, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h55, 8, 24,  8'h22, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h55, 0, 32,  8'h22, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8, 24,  8'h33, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8, 16,  8'h44, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8,  8,  8'h55, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8,  0,  8'h00, 8, 0, 0, 0, 1));
    // Same-edge consume 3 and append FF
    vecs.push_back(mk(0, 1, 1, 8'h80, 0,  8,  8'h80, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'hFF, 3, 13,  8'h07, 5, 1, 0, 0, 1));
    // fwd=9 saturates to 8, then underflow, en=0 hold, flush with en=0
    vecs.push_back(mk(0, 1, 0, 8'h00, 9,  5,  8'hF8, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,  4,  8'hF0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 6,  4,  8'hF0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 8'h12, 2,  4,  8'hF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0,  0,  8'h00, 8, 0, 0, 0, 0));

    rst = 1'b1;
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'hAA, 3);
    checkAll(-1, mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].flush, vecs[i].en, vecs[i].bv, vecs[i].data, vecs[i].fwd);
      checkAll(i, vecs[i]);
    end

    // A nonzero byte breaks the zero run, so 00 01 00 03 keeps its 03
    applyStimulus(0, 1, 1, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h01, 0);
    applyStimulus(0, 1, 1, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h03, 0);
    checkOutput("no_epb_after_break", 100, 8'(o_epb_removed), 8'h0);
    checkOutput("avail_after_break", 100, 8'(o_bits_avail), 8'd32);
    applyStimulus(0, 1, 0, 8'h00, 8);
    applyStimulus(0, 1, 0, 8'h00, 8);
    applyStimulus(0, 1, 0, 8'h00, 8);
    checkOutput("kept_03_byte", 101, o_rbsp_out, 8'h03);
    checkOutput("kept_03_zeros", 101, 8'(o_num_zero_bits), 8'd6);

    // Flush clears the zero run: 00 00 | flush | 03 keeps the 03
    applyStimulus(1, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h00, 0);
    applyStimulus(1, 1, 1, 8'h03, 0);
    checkOutput("flush_ignores_byte", 102, 8'(o_bits_avail), 8'd0);
    applyStimulus(0, 1, 1, 8'h03, 0);
    checkOutput("flush_clears_run", 103, o_rbsp_out, 8'h03);
    checkOutput("flush_no_epb", 103, 8'(o_epb_removed), 8'h0);

    // Reset in mid-stream clears everything
    applyStimulus(0, 1, 1, 8'hC3, 0);
    rst = 1'b1;
    applyStimulus(0, 1, 1, 8'hC3, 0);
    checkOutput("reset_avail", 104, 8'(o_bits_avail), 8'd0);
    checkOutput("reset_ready", 104, 8'(o_byte_ready), 8'h0);
    checkOutput("reset_zeros", 104, 8'(o_num_zero_bits), 8'd8);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
